// File: rtl/id_pkg.sv
// ============================================================================
// Module : id_pkg
// Brief  : Shared RV32I decode constants, ALU codes, immediate types and the
//          ID/EX pipeline-register record.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package id_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_we;
      logic        branch;
      logic        jump;
      logic        illegal;
      logic        valid;
   } idex_t;

   function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e kind);
      logic [31:0] imm;
      imm = '0;
      case (kind)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'h000};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_if.sv
// ============================================================================
// Module : id_stage_if
// Brief  : Fetch/writeback/control inputs and ID/EX register outputs of the
//          decode stage, bundled with master (driver) and slave (stage) views.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface id_stage_if;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] instr_i;
   logic [31:0] pc_i;
   logic        valid_i;
   logic        wb_we_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;

   logic        hazard_o;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic [31:0] rs1_data_o;
   logic [31:0] rs2_data_o;
   logic [31:0] imm_o;
   logic [4:0]  rs1_o;
   logic [4:0]  rs2_o;
   logic [4:0]  rd_o;
   logic [2:0]  funct3_o;
   logic [3:0]  alu_op_o;
   logic        alu_src_o;
   logic        mem_rd_o;
   logic        mem_wr_o;
   logic        reg_we_o;
   logic        branch_o;
   logic        jump_o;
   logic        illegal_o;
   logic        valid_o;

   modport slave (
      input  stall_i, flush_i, instr_i, pc_i, valid_i, wb_we_i, wb_rd_i, wb_data_i,
      output hazard_o, pc_o, instr_o, rs1_data_o, rs2_data_o, imm_o, rs1_o, rs2_o, rd_o,
             funct3_o, alu_op_o, alu_src_o, mem_rd_o, mem_wr_o, reg_we_o, branch_o,
             jump_o, illegal_o, valid_o
   );

   modport master (
      output stall_i, flush_i, instr_i, pc_i, valid_i, wb_we_i, wb_rd_i, wb_data_i,
      input  hazard_o, pc_o, instr_o, rs1_data_o, rs2_data_o, imm_o, rs1_o, rs2_o, rd_o,
             funct3_o, alu_op_o, alu_src_o, mem_rd_o, mem_wr_o, reg_we_o, branch_o,
             jump_o, illegal_o, valid_o
   );
endinterface

`default_nettype wire

// File: rtl/id_stage_regfile.sv
// ============================================================================
// Module : id_stage_regfile
// Brief  : 32x32 register file, 2 combinational reads, 1 synchronous write.
//          RF_BYPASS_EN makes a same-cycle write visible on the read ports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_stage_regfile (
   input  wire logic        clk_i,
   input  wire logic        i_we,
   input  wire logic [4:0]  i_waddr,
   input  wire logic [31:0] i_wdata,
   input  wire logic [4:0]  i_raddr1,
   input  wire logic [4:0]  i_raddr2,
   output logic      [31:0] o_rdata1,
   output logic      [31:0] o_rdata2
);

   // Contents are deliberately not reset; x0 is never written and reads as 0.
   logic [31:0] r_mem [32];

   always_ff @(posedge clk_i) begin
      if (i_we && (i_waddr != 5'd0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      o_rdata1 = (i_raddr1 == 5'd0) ? 32'h0 : r_mem[i_raddr1];
      o_rdata2 = (i_raddr2 == 5'd0) ? 32'h0 : r_mem[i_raddr2];
`ifdef RF_BYPASS_EN
      if (i_we && (i_waddr == i_raddr1) && (i_raddr1 != 5'd0)) begin
         o_rdata1 = i_wdata;
      end
      if (i_we && (i_waddr == i_raddr2) && (i_raddr2 != 5'd0)) begin
         o_rdata2 = i_wdata;
      end
`endif
   end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module : id_stage
// Brief  : RV32I decode stage: field decode, immediate generation, register
//          read, load-use detection, ID/EX register. Optional: RF_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_stage
   import id_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = id_pkg::NOP_INSTR
) (
   input  wire logic clk_i,
   input  wire logic rst_i,
   id_stage_if.slave bus
);

   localparam idex_t c_bubble = '{pc: RESET_PC, instr: NOP_INSTR, default: '0};

   logic [6:0]  w_opcode;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [4:0]  w_rd;
   logic [2:0]  w_funct3;
   logic        w_funct7b5;
   imm_type_e   w_imm_type;
   logic [3:0]  w_alu_op;
   logic        w_alu_src;
   logic        w_reg_we;
   logic        w_mem_rd;
   logic        w_mem_wr;
   logic        w_branch;
   logic        w_jump;
   logic        w_illegal;
   logic        w_use_rs1;
   logic        w_use_rs2;
   logic [31:0] w_rs1_data;
   logic [31:0] w_rs2_data;
   logic        w_hazard;
   idex_t       w_next;
   idex_t       r_idex;

   assign w_opcode   = bus.instr_i[6:0];
   assign w_rd       = bus.instr_i[11:7];
   assign w_funct3   = bus.instr_i[14:12];
   assign w_rs1      = bus.instr_i[19:15];
   assign w_rs2      = bus.instr_i[24:20];
   assign w_funct7b5 = bus.instr_i[30];

   always_comb begin
      w_imm_type = IMM_NONE;
      w_alu_op   = ALU_ADD;
      w_alu_src  = 1'b0;
      w_reg_we   = 1'b0;
      w_mem_rd   = 1'b0;
      w_mem_wr   = 1'b0;
      w_branch   = 1'b0;
      w_jump     = 1'b0;
      w_illegal  = 1'b0;
      w_use_rs1  = 1'b0;
      w_use_rs2  = 1'b0;
      case (w_opcode)
         OPC_LUI: begin
            w_imm_type = IMM_U;
            w_alu_op   = ALU_PASSB;
            w_alu_src  = 1'b1;
            w_reg_we   = 1'b1;
         end
         OPC_AUIPC: begin
            w_imm_type = IMM_U;
            w_alu_src  = 1'b1;
            w_reg_we   = 1'b1;
         end
         OPC_JAL: begin
            w_imm_type = IMM_J;
            w_alu_src  = 1'b1;
            w_reg_we   = 1'b1;
            w_jump     = 1'b1;
         end
         OPC_JALR: begin
            w_imm_type = IMM_I;
            w_alu_src  = 1'b1;
            w_reg_we   = 1'b1;
            w_jump     = 1'b1;
            w_use_rs1  = 1'b1;
         end
         OPC_BRANCH: begin
            w_imm_type = IMM_B;
            w_branch   = 1'b1;
            w_use_rs1  = 1'b1;
            w_use_rs2  = 1'b1;
         end
         OPC_LOAD: begin
            w_imm_type = IMM_I;
            w_alu_src  = 1'b1;
            w_reg_we   = 1'b1;
            w_mem_rd   = 1'b1;
            w_use_rs1  = 1'b1;
         end
         OPC_STORE: begin
            w_imm_type = IMM_S;
            w_alu_src  = 1'b1;
            w_mem_wr   = 1'b1;
            w_use_rs1  = 1'b1;
            w_use_rs2  = 1'b1;
         end
         OPC_OP_IMM, OPC_OP: begin
            w_imm_type = (w_opcode == OPC_OP) ? IMM_NONE : IMM_I;
            w_alu_src  = (w_opcode == OPC_OP_IMM);
            w_reg_we   = 1'b1;
            w_use_rs1  = 1'b1;
            w_use_rs2  = (w_opcode == OPC_OP);
            case (w_funct3)
               3'b000:  w_alu_op = (w_opcode == OPC_OP && w_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  w_alu_op = ALU_SLL;
               3'b010:  w_alu_op = ALU_SLT;
               3'b011:  w_alu_op = ALU_SLTU;
               3'b100:  w_alu_op = ALU_XOR;
               3'b101:  w_alu_op = w_funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  w_alu_op = ALU_OR;
               default: w_alu_op = ALU_AND;
            endcase
         end
         OPC_FENCE, OPC_SYSTEM: begin
            w_imm_type = IMM_I;
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   id_stage_regfile u_regfile (
      .clk_i    (clk_i),
      .i_we     (bus.wb_we_i),
      .i_waddr  (bus.wb_rd_i),
      .i_wdata  (bus.wb_data_i),
      .i_raddr1 (w_rs1),
      .i_raddr2 (w_rs2),
      .o_rdata1 (w_rs1_data),
      .o_rdata2 (w_rs2_data)
   );

   // Once the bubble is in ID/EX the load is gone, so this self-clears.
   assign w_hazard = r_idex.valid & r_idex.mem_rd & (r_idex.rd != 5'd0) & bus.valid_i
                   & ((w_use_rs1 & (r_idex.rd == w_rs1)) | (w_use_rs2 & (r_idex.rd == w_rs2)))
                   & ~bus.flush_i;

   always_comb begin
      w_next          = c_bubble;
      w_next.pc       = bus.pc_i;
      w_next.instr    = bus.instr_i;
      w_next.rs1_data = w_rs1_data;
      w_next.rs2_data = w_rs2_data;
      w_next.imm      = gen_imm(bus.instr_i, w_imm_type);
      w_next.rs1      = w_rs1;
      w_next.rs2      = w_rs2;
      w_next.rd       = w_rd;
      w_next.funct3   = w_funct3;
      w_next.alu_op   = w_alu_op;
      w_next.alu_src  = w_alu_src;
      w_next.mem_rd   = w_mem_rd & bus.valid_i;
      w_next.mem_wr   = w_mem_wr & bus.valid_i;
      w_next.reg_we   = w_reg_we & bus.valid_i & (w_rd != 5'd0);
      w_next.branch   = w_branch & bus.valid_i;
      w_next.jump     = w_jump & bus.valid_i;
      w_next.illegal  = w_illegal & bus.valid_i;
      w_next.valid    = bus.valid_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_idex <= c_bubble;
      end else if (bus.flush_i) begin
         r_idex <= c_bubble;
      end else if (bus.stall_i) begin
         r_idex <= r_idex;
      end else if (w_hazard) begin
         r_idex <= c_bubble;
      end else begin
         r_idex <= w_next;
      end
   end

   assign bus.hazard_o   = w_hazard;
   assign bus.pc_o       = r_idex.pc;
   assign bus.instr_o    = r_idex.instr;
   assign bus.rs1_data_o = r_idex.rs1_data;
   assign bus.rs2_data_o = r_idex.rs2_data;
   assign bus.imm_o      = r_idex.imm;
   assign bus.rs1_o      = r_idex.rs1;
   assign bus.rs2_o      = r_idex.rs2;
   assign bus.rd_o       = r_idex.rd;
   assign bus.funct3_o   = r_idex.funct3;
   assign bus.alu_op_o   = r_idex.alu_op;
   assign bus.alu_src_o  = r_idex.alu_src;
   assign bus.mem_rd_o   = r_idex.mem_rd;
   assign bus.mem_wr_o   = r_idex.mem_wr;
   assign bus.reg_we_o   = r_idex.reg_we;
   assign bus.branch_o   = r_idex.branch;
   assign bus.jump_o     = r_idex.jump;
   assign bus.illegal_o  = r_idex.illegal;
   assign bus.valid_o    = r_idex.valid;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// Module : tb_id_stage
// Brief  : Directed, table-driven bench for the id_stage decode stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_id_stage;
   import id_pkg::*;

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        src;
      logic        we;
      logic        mrd;
      logic        mwr;
      logic        br;
      logic        jmp;
      logic        ill;
      logic [4:0]  rd;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_err;
   vec_t vecs[14];

   id_stage_if bus ();

   id_stage dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic valid);
      bus.instr_i = instr;
      bus.pc_i    = pc;
      bus.valid_i = valid;
   endtask

   task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
      bus.wb_we_i   = we;
      bus.wb_rd_i   = rd;
      bus.wb_data_i = data;
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      //              instr         v  imm           alu        s  we mr mw br j  il rd
      vecs[0]  = '{32'hFFF28313, 1, 32'hFFFFFFFF, ALU_ADD,   1, 1, 0, 0, 0, 0, 0, 5'd6};
      vecs[1]  = '{32'hFE000CE3, 1, 32'hFFFFFFF8, ALU_ADD,   0, 0, 0, 0, 1, 0, 0, 5'd25};
      vecs[2]  = '{32'h0000037F, 1, 32'h00000000, ALU_ADD,   0, 0, 0, 0, 0, 0, 1, 5'd6};
      vecs[3]  = '{32'h123451B7, 1, 32'h12345000, ALU_PASSB, 1, 1, 0, 0, 0, 0, 0, 5'd3};
      vecs[4]  = '{32'hFE20AE23, 1, 32'hFFFFFFFC, ALU_ADD,   1, 0, 0, 1, 0, 0, 0, 5'd28};
      vecs[5]  = '{32'h008000EF, 1, 32'h00000008, ALU_ADD,   1, 1, 0, 0, 0, 1, 0, 5'd1};
      vecs[6]  = '{32'hFFDFF06F, 1, 32'hFFFFFFFC, ALU_ADD,   1, 0, 0, 0, 0, 1, 0, 5'd0};
      vecs[7]  = '{32'h4032D213, 1, 32'h00000403, ALU_SRA,   1, 1, 0, 0, 0, 0, 0, 5'd4};
      vecs[8]  = '{32'h40238433, 1, 32'h00000000, ALU_SUB,   0, 1, 0, 0, 0, 0, 0, 5'd8};
      vecs[9]  = '{32'h40000093, 1, 32'h00000400, ALU_ADD,   1, 1, 0, 0, 0, 0, 0, 5'd1};
      vecs[10] = '{32'h80000297, 1, 32'h80000000, ALU_ADD,   1, 1, 0, 0, 0, 0, 0, 5'd5};
      vecs[11] = '{32'h00000073, 1, 32'h00000000, ALU_ADD,   0, 0, 0, 0, 0, 0, 0, 5'd0};
      vecs[12] = '{32'h0000A383, 1, 32'h00000000, ALU_ADD,   1, 1, 1, 0, 0, 0, 0, 5'd7};
      vecs[13] = '{32'hFFF28313, 0, 32'hFFFFFFFF, ALU_ADD,   1, 0, 0, 0, 0, 0, 0, 5'd6};

      rst = 1'b1;
      bus.stall_i = 1'b0;
      bus.flush_i = 1'b0;
      drive(NOP_INSTR, 32'h0, 1'b0);
      wb(1'b0, 5'd0, 32'h0);
      tick();
      tick();
      chk("rst.valid", {31'h0, bus.valid_o}, 32'h0);
      chk("rst.instr", bus.instr_o, 32'h00000013);
      chk("rst.pc", bus.pc_o, 32'h0);
      chk("rst.reg_we", {31'h0, bus.reg_we_o}, 32'h0);
      rst = 1'b0;

      // Preload operands, then addi x6,x5,-1 reads the written x5
      wb(1'b1, 5'd1, 32'h0000_0100); tick();
      wb(1'b1, 5'd2, 32'h0000_0022); tick();
      wb(1'b1, 5'd5, 32'hDEAD_BEEF); tick();
      wb(1'b0, 5'd0, 32'h0);
      drive(32'hFFF28313, 32'h0000_0040, 1'b1);
      tick();
      chk("addi.rs1_data", bus.rs1_data_o, 32'hDEADBEEF);
      chk("addi.imm", bus.imm_o, 32'hFFFFFFFF);
      chk("addi.alu_op", {28'h0, bus.alu_op_o}, {28'h0, ALU_ADD});
      chk("addi.alu_src", {31'h0, bus.alu_src_o}, 32'h1);
      chk("addi.rd", {27'h0, bus.rd_o}, 32'd6);
      chk("addi.valid", {31'h0, bus.valid_o}, 32'h1);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].instr, 32'h100 + 32'(4 * i), vecs[i].valid);
         tick();
         chk($sformatf("v%0d.valid", i), {31'h0, bus.valid_o}, {31'h0, vecs[i].valid});
         chk($sformatf("v%0d.pc", i), bus.pc_o, 32'h100 + 32'(4 * i));
         chk($sformatf("v%0d.instr", i), bus.instr_o, vecs[i].instr);
         chk($sformatf("v%0d.imm", i), bus.imm_o, vecs[i].imm);
         chk($sformatf("v%0d.alu_op", i), {28'h0, bus.alu_op_o}, {28'h0, vecs[i].alu});
         chk($sformatf("v%0d.alu_src", i), {31'h0, bus.alu_src_o}, {31'h0, vecs[i].src});
         chk($sformatf("v%0d.reg_we", i), {31'h0, bus.reg_we_o}, {31'h0, vecs[i].we});
         chk($sformatf("v%0d.mem_rd", i), {31'h0, bus.mem_rd_o}, {31'h0, vecs[i].mrd});
         chk($sformatf("v%0d.mem_wr", i), {31'h0, bus.mem_wr_o}, {31'h0, vecs[i].mwr});
         chk($sformatf("v%0d.branch", i), {31'h0, bus.branch_o}, {31'h0, vecs[i].br});
         chk($sformatf("v%0d.jump", i), {31'h0, bus.jump_o}, {31'h0, vecs[i].jmp});
         chk($sformatf("v%0d.illegal", i), {31'h0, bus.illegal_o}, {31'h0, vecs[i].ill});
         chk($sformatf("v%0d.rd", i), {27'h0, bus.rd_o}, {27'h0, vecs[i].rd});
      end

      // Load-use: lw x7,0(x1) then add x8,x7,x2
      drive(32'h0000A383, 32'h0000_0200, 1'b1);
      tick();
      drive(32'h00708513, 32'h0000_0204, 1'b1);   // addi x10,x1,7: rs2 field aliases x7
      #1;
      chk("lu.hazard_itype", {31'h0, bus.hazard_o}, 32'h0);
      drive(32'h00238433, 32'h0000_0204, 1'b1);
      #1;
      chk("lu.hazard", {31'h0, bus.hazard_o}, 32'h1);
      tick();
      chk("lu.bubble_valid", {31'h0, bus.valid_o}, 32'h0);
      chk("lu.bubble_instr", bus.instr_o, 32'h00000013);
      chk("lu.bubble_mem_rd", {31'h0, bus.mem_rd_o}, 32'h0);
      chk("lu.hazard_clear", {31'h0, bus.hazard_o}, 32'h0);
      tick();
      chk("lu.add_valid", {31'h0, bus.valid_o}, 32'h1);
      chk("lu.add_instr", bus.instr_o, 32'h00238433);
      chk("lu.add_pc", bus.pc_o, 32'h0000_0204);
      chk("lu.add_rs2_data", bus.rs2_data_o, 32'h0000_0022);
      chk("lu.add_rd", {27'h0, bus.rd_o}, 32'd8);

      // Flush beats stall and hazard
      drive(32'h0000A383, 32'h0000_0300, 1'b1);
      tick();
      drive(32'h00238433, 32'h0000_0304, 1'b1);
      bus.stall_i = 1'b1;
      #1;
      chk("fl.hazard_under_stall", {31'h0, bus.hazard_o}, 32'h1);
      bus.flush_i = 1'b1;
      #1;
      chk("fl.hazard_masked", {31'h0, bus.hazard_o}, 32'h0);
      tick();
      chk("fl.valid", {31'h0, bus.valid_o}, 32'h0);
      chk("fl.instr", bus.instr_o, 32'h00000013);
      chk("fl.pc", bus.pc_o, 32'h0);
      chk("fl.mem_rd", {31'h0, bus.mem_rd_o}, 32'h0);
      bus.flush_i = 1'b0;
      bus.stall_i = 1'b0;
      drive(32'h123451B7, 32'h0000_0400, 1'b1);
      tick();
      bus.stall_i = 1'b1;
      drive(32'hFFF28313, 32'h0000_0404, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("st%0d.instr", c), bus.instr_o, 32'h123451B7);
         chk($sformatf("st%0d.pc", c), bus.pc_o, 32'h0000_0400);
         chk($sformatf("st%0d.imm", c), bus.imm_o, 32'h12345000);
         chk($sformatf("st%0d.valid", c), {31'h0, bus.valid_o}, 32'h1);
      end
      bus.stall_i = 1'b0;

      // Same-cycle writeback and read of x9
      drive(NOP_INSTR, 32'h0, 1'b0);
      wb(1'b1, 5'd9, 32'h0000_1111);
      tick();
      wb(1'b1, 5'd9, 32'h0000_1234);
      drive(32'h00048513, 32'h0000_0500, 1'b1);
      tick();
`ifdef RF_BYPASS_EN
      chk("rf.same_cycle", bus.rs1_data_o, 32'h0000_1234);
`else
      chk("rf.same_cycle", bus.rs1_data_o, 32'h0000_1111);
`endif
      wb(1'b0, 5'd0, 32'h0);
      tick();
      chk("rf.after_write", bus.rs1_data_o, 32'h0000_1234);
      wb(1'b1, 5'd0, 32'hFFFF_FFFF);
      drive(32'h00000593, 32'h0000_0504, 1'b1);
      tick();
      chk("rf.x0_same_cycle", bus.rs1_data_o, 32'h0);
      wb(1'b0, 5'd0, 32'h0);
      tick();
      chk("rf.x0_after", bus.rs1_data_o, 32'h0);

      // Asynchronous reset in the middle of traffic
      drive(32'h123451B7, 32'h0000_0600, 1'b1);
      tick();
      chk("mr.pre_valid", {31'h0, bus.valid_o}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("mr.valid", {31'h0, bus.valid_o}, 32'h0);
      chk("mr.instr", bus.instr_o, 32'h00000013);
      chk("mr.pc", bus.pc_o, 32'h0);
      tick();
      rst = 1'b0;
      chk("mr.imm", bus.imm_o, 32'h0);
      drive(32'h00000593, 32'h0000_0604, 1'b1);
      tick();
      chk("mr.x0_read", bus.rs1_data_o, 32'h0);
      chk("mr.resume_valid", {31'h0, bus.valid_o}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
